// File: rtl/hack_vector_checker.sv
// hack_vector_checker
// Vector-driven checker that sits beside a Hack-style DUT. It fetches packed vectors
// {stim, expected, mask} from a synchronous ROM, drives stim to the DUT, pulses one DUT
// step per vector and compares the DUT result against the masked expected value.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, stop_on_fail    run request; halt-on-first-mismatch (sampled at start)
//   num_vec                vectors to run (sampled at start, saturated to 2^ADDR_W)
//   vec_addr, vec_rd       ROM read port (data valid on vec_rdata one cycle later)
//   vec_rdata              ROM word {stim, expected, mask}
//   dut_stim, dut_step     DUT stimulus and one-cycle step enable
//   dut_result             DUT outputs, same packing as expected
//   busy, done             run status
//   pass_cnt, fail_cnt     match / mismatch counters
//   first_fail_*           record of the first mismatching vector
module hack_vector_checker #(
    parameter int unsigned STIM_W = 33,
    parameter int unsigned CHK_W  = 47,
    parameter int unsigned ADDR_W = 7,
    localparam int unsigned VEC_W = STIM_W + 2 * CHK_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop_on_fail,
    input  logic [ADDR_W:0]   num_vec,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_rd,
    input  logic [VEC_W-1:0]  vec_rdata,
    output logic [STIM_W-1:0] dut_stim,
    output logic              dut_step,
    input  logic [CHK_W-1:0]  dut_result,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [CHK_W-1:0]  first_fail_diff
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStep,
        StCheck,
        StDone
    } state_e;

    localparam logic [ADDR_W:0]   MaxVec = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CntOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IdxOne = {{(ADDR_W - 1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     num_q, num_d;
    logic                stop_q, stop_d;
    logic [STIM_W-1:0]   stim_q, stim_d;
    logic [CHK_W-1:0]    exp_q, exp_d;
    logic [CHK_W-1:0]    mask_q, mask_d;
    logic [ADDR_W:0]     pass_q, pass_d;
    logic [ADDR_W:0]     fail_q, fail_d;
    logic                ff_valid_q, ff_valid_d;
    logic [ADDR_W-1:0]   ff_idx_q, ff_idx_d;
    logic [CHK_W-1:0]    ff_diff_q, ff_diff_d;

    logic [CHK_W-1:0]    diff;
    logic                vec_fail;
    logic                last_vec;

    assign diff     = (dut_result ^ exp_q) & mask_q;
    assign vec_fail = |diff;
    assign last_vec = ({1'b0, idx_q} == (num_q - CntOne));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        stop_d     = stop_q;
        stim_d     = stim_q;
        exp_d      = exp_q;
        mask_d     = mask_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_diff_d  = ff_diff_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pass_d     = '0;
                    fail_d     = '0;
                    ff_valid_d = 1'b0;
                    ff_idx_d   = '0;
                    ff_diff_d  = '0;
                    idx_d      = '0;
                    num_d      = (num_vec > MaxVec) ? MaxVec : num_vec;
                    stop_d     = stop_on_fail;
                    state_d    = (num_vec == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                {stim_d, exp_d, mask_d} = vec_rdata;
                state_d = StStep;
            end
            StStep: state_d = StCheck;
            StCheck: begin
                if (vec_fail) begin
                    fail_d = fail_q + CntOne;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_idx_d   = idx_q;
                        ff_diff_d  = diff;
                    end
                end else begin
                    pass_d = pass_q + CntOne;
                end
                if (last_vec || (vec_fail && stop_q)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            num_q      <= '0;
            stop_q     <= 1'b0;
            stim_q     <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_diff_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            stop_q     <= stop_d;
            stim_q     <= stim_d;
            exp_q      <= exp_d;
            mask_q     <= mask_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_diff_q  <= ff_diff_d;
        end
    end

    assign vec_addr         = idx_q;
    assign vec_rd           = (state_q == StFetch);
    assign dut_step         = (state_q == StStep);
    assign dut_stim         = stim_q;
    assign busy             = (state_q == StFetch) || (state_q == StLoad) ||
                              (state_q == StStep) || (state_q == StCheck);
    assign done             = (state_q == StDone);
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_diff  = ff_diff_q;

endmodule
